// File: rtl/test_core_if.sv
// Single-bit conditioner signal bundle.
//   in   : raw asynchronous level, driven by the source (master)
//   out  : filtered registered level, driven by the conditioner (slave)
//   rise : one-cycle pulse when out goes 0->1
//   fall : one-cycle pulse when out goes 1->0
interface test_core_if;
   logic in;
   logic out;
   logic rise;
   logic fall;

   modport master (output in,  input  out, rise, fall);
   modport slave  (input  in,  output out, rise, fall);
endinterface

// File: rtl/test_core.sv
// test_core: leaf input conditioner for a raw 1-bit signal.
// Synchronises tio.in into clk, debounces it with a stable-count filter and
// drives the filtered level plus registered edge pulses.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   tio   : test_core_if.slave (in -> conditioner, out/rise/fall <- conditioner)
// Parameters:
//   SYNC_STAGES   : synchroniser depth (2..4)
//   FILTER_CYCLES : consecutive mismatching cycles before out follows (1..255)
//   OUT_RESET     : reset value of out and of every synchroniser flop
module test_core #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 4,
   parameter logic OUT_RESET     = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   test_core_if.slave tio
);

   localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   // synchroniser: plain flop chain, nothing between stages
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= {SYNC_STAGES{OUT_RESET}};
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], tio.in};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // filter state
   logic [CW-1:0] cnt, cnt_d;
   logic          out_q, out_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Any return of s to out clears the count, so short excursions earn no
   // credit. The pulses are computed from the same decision that flips out,
   // so they land on the exact edge out changes.
   always_comb begin
      cnt_d  = cnt;
      out_d  = out_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s == out_q) begin
         cnt_d = '0;
      end else if (cnt == CNT_LAST) begin
         cnt_d  = '0;
         out_d  = s;
         rise_d = s;
         fall_d = ~s;
      end else begin
         cnt_d = cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         out_q  <= OUT_RESET;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt    <= cnt_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign tio.out  = out_q;
   assign tio.rise = rise_q;
   assign tio.fall = fall_q;

endmodule

// File: tb/tb_test_core.sv
// Directed bench for test_core: defaults (2 sync, filter 4) on dut0 and a
// pass-through corner (3 sync, filter 1) on dut1, both fed the same input.
module tb_test_core;

   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   test_core_if tio0 ();
   test_core_if tio1 ();

   test_core #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .OUT_RESET(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .tio(tio0));
   test_core #(.SYNC_STAGES(3), .FILTER_CYCLES(1), .OUT_RESET(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .tio(tio1));

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_in(input logic v);
      tio0.in = v;
      tio1.in = v;
   endtask

   // advance one edge, land 1 ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run n edges, checking both DUTs each cycle. r*/f* give the step index
   // (1-based, 0 = never) of the expected rise/fall pulse; out starts at o0.
   // If flip != 0, in is inverted right after the checks of that step.
   task automatic watch(input string tag, input int n, input int flip, input logic o0,
                        input int r0, input int f0, input int r1, input int f1);
      logic e0, e1;
      e0 = o0;
      e1 = o0;
      for (int k = 1; k <= n; k++) begin
         step();
         if (k == r0) e0 = 1'b1;
         if (k == f0) e0 = 1'b0;
         if (k == r1) e1 = 1'b1;
         if (k == f1) e1 = 1'b0;
         chk({tag, "_out0"},  8'(tio0.out),  8'(e0));
         chk({tag, "_rise0"}, 8'(tio0.rise), 8'(k == r0));
         chk({tag, "_fall0"}, 8'(tio0.fall), 8'(k == f0));
         chk({tag, "_out1"},  8'(tio1.out),  8'(e1));
         chk({tag, "_rise1"}, 8'(tio1.rise), 8'(k == r1));
         chk({tag, "_fall1"}, 8'(tio1.fall), 8'(k == f1));
         if (k == flip) set_in(~tio0.in);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b0);

      // reset held while in toggles: everything stays quiet
      for (int i = 0; i < 6; i++) begin
         set_in(~tio0.in);
         step();
         chk("rst_out0",  8'(tio0.out),  8'h0);
         chk("rst_rise0", 8'(tio0.rise), 8'h0);
         chk("rst_fall0", 8'(tio0.fall), 8'h0);
         chk("rst_out1",  8'(tio1.out),  8'h0);
      end
      set_in(1'b0);
      rst_n = 1'b1;
      watch("rel", 20, 0, 1'b0, 0, 0, 0, 0);

      // clean steps: 6 edges on defaults, 4 on the filter-1 corner
      set_in(1'b1);
      watch("up", 10, 0, 1'b0, 6, 0, 4, 0);
      set_in(1'b0);
      watch("dn", 10, 0, 1'b1, 0, 6, 0, 4);

      // 3-cycle glitch is rejected by dut0, passed through by dut1
      set_in(1'b1);
      watch("g3", 12, 3, 1'b0, 0, 0, 4, 7);
      // 4-cycle pulse just qualifies
      set_in(1'b1);
      watch("g4", 14, 4, 1'b0, 6, 10, 4, 8);

      // toggle every cycle: out never moves, counter never passes 1
      for (int i = 0; i < 20; i++) begin
         set_in((i % 2) == 0);
         step();
         chk("tog_out0",  8'(tio0.out),  8'h0);
         chk("tog_rise0", 8'(tio0.rise), 8'h0);
         chk("tog_cnt",   8'(dut0.cnt > 1), 8'h0);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         chk("tog_settle0", 8'(tio0.out), 8'h0);
      end

      // reset in the middle of a filter run
      set_in(1'b1);
      watch("pre", 4, 0, 1'b0, 0, 0, 4, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_async_out0", 8'(tio0.out), 8'h0);
      chk("mid_async_out1", 8'(tio1.out), 8'h0);
      chk("mid_async_fall1", 8'(tio1.fall), 8'h0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("mid_out0",  8'(tio0.out),  8'h0);
         chk("mid_rise0", 8'(tio0.rise), 8'h0);
         chk("mid_out1",  8'(tio1.out),  8'h0);
         chk("mid_fall1", 8'(tio1.fall), 8'h0);
      end
      rst_n = 1'b1;
      watch("post", 10, 0, 1'b0, 6, 0, 4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/test_core.md
Name: test_core

Overview:
- Single-bit input conditioner for the `test` path.
- Synchronises the asynchronous input `in` into the `clk` domain.
- Debounces it with a stable-count filter, drives the filtered level on `out`, and emits one-cycle edge pulses.
- Used as the leaf conditioning block wherever a raw 1-bit signal enters synchronous logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `in`. Legal range 2..4.
- FILTER_CYCLES, 4, consecutive cycles the synchronised input must differ from `out` before `out` follows. Legal range 1..255.
- OUT_RESET, 1'b0, value of `out` and of all synchroniser flops during reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in  input  1  raw asynchronous level input.
- out  output  1  filtered, registered level.
- rise  output  1  one-cycle pulse when `out` goes 0->1.
- fall  output  1  one-cycle pulse when `out` goes 1->0.

Behaviour:
- Clocking and reset:
  - One clock domain. rst_n=0 asynchronously clears all state; deassertion takes effect on the next rising edge.
  - Reset values: out=OUT_RESET; rise=0; fall=0; all synchroniser flops=OUT_RESET; filter counter=0.
- Synchroniser:
  - Chain of SYNC_STAGES flops; `s` = last stage.
  - No logic between stages.
- Filter counter:
  - Counter `cnt`, width $clog2(FILTER_CYCLES+1), minimum 1 bit.
  - Each edge, if s==out: cnt<=0, out holds.
  - If s!=out and cnt<FILTER_CYCLES-1: cnt<=cnt+1, out holds.
  - If s!=out and cnt==FILTER_CYCLES-1: out<=s, cnt<=0.
- Latency:
  - A clean level change on `in` appears on `out` exactly SYNC_STAGES+FILTER_CYCLES rising edges later.
  - With defaults this is 6 cycles.
- Glitch rejection:
  - Any excursion of `s` lasting fewer than FILTER_CYCLES cycles is ignored.
  - Returning to s==out resets cnt to 0; no partial credit is carried.
- Edge pulses:
  - Registered; rise=1 on the same edge out goes 0->1, and fall likewise for 1->0.
  - Each pulse lasts exactly one cycle; rise and fall are never both 1.
  - Minimum spacing between opposite pulses is FILTER_CYCLES cycles.
- FILTER_CYCLES=1: `out` equals `s` delayed by one cycle (pure synchroniser plus register).
- Reset mid-filter: counter discarded, out=OUT_RESET, no pulse generated on reset assertion or release.
- `in` is read only through the synchroniser; `out`, `rise` and `fall` are glitch-free flop outputs.
- No X propagation from `in` into `out` after the synchroniser has been loaded with a known value.

Test Plan:
- Reset: rst_n=0 with in=1 toggling -> out=0, rise=0, fall=0 throughout. Release with in=0 -> out stays 0 indefinitely.
- Step up (defaults): in 0->1 held -> out=1 exactly 6 edges later, rise=1 for exactly that one cycle, fall=0.
- Step down: from out=1, in 1->0 held -> out=0 after 6 edges, fall pulses for one cycle.
- Glitch: in=1 for 3 cycles then 0 (FILTER_CYCLES=4) -> out stays 0, no pulses. in=1 for 4 cycles -> out rises once.
- Toggle every cycle (in=0,1,0,1 at one-cycle intervals, 10 ns steps) -> out never changes; cnt never exceeds 1.
- Reset mid-operation: in 0->1, assert rst_n=0 after 4 cycles, release, keep in=1 -> out=0 during reset, then out=1 exactly 6 edges after release with a single rise pulse.
